// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage.
// Serves loads and stores from a single-port word array that takes LATENCY
// cycles per access, and stalls the pipeline while an access is in progress.
// A one-entry posted-write buffer lets stores retire without stalling.
// Optional feature: define DMEM_RESP_FWD_EN to enable store-to-load
// forwarding from the write buffer.
module dmem_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic        quiesced
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_WB  = 2'd1;
    localparam logic [1:0] RD_BUSY  = 2'd2;
    localparam logic [1:0] RD_DONE  = 2'd3;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [15:0]       mem_r [0:(2**ADDR_W)-1];
    logic [1:0]        state_r;
    logic [3:0]        cnt_r;
    logic [3:0]        dcnt_r;
    logic              wb_vld_r;
    logic [ADDR_W-1:0] wb_addr_r;
    logic [15:0]       wb_data_r;
    logic [15:0]       rd_data_r;

    logic [ADDR_W-1:0] addr_idx_s;
    logic              drain_done_s;
    logic              wr_accept_s;
    logic              fwd_hit_s;
    logic              unused_addr_s;

    assign addr_idx_s    = addr[ADDR_W-1:0];
    assign unused_addr_s = ^addr[15:ADDR_W];

    // Drain finishes in the cycle its countdown reaches zero.
    assign drain_done_s = wb_vld_r && (dcnt_r == 4'd0);

    // A store is taken when the buffer is free or frees up on this edge.
    assign wr_accept_s = we && (state_r == IDLE) && (!wb_vld_r || drain_done_s);

`ifdef DMEM_RESP_FWD_EN
    // Load hits the posted store: answer straight from the buffer.
    always_comb begin
        fwd_hit_s = re && !we && (state_r == IDLE) && wb_vld_r && (wb_addr_r == addr_idx_s);
    end
`else
    // Without forwarding every load goes to the array.
    always_comb begin
        fwd_hit_s = 1'b0;
    end
`endif

    // Write buffer: capture accepted stores and count down their drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_vld_r  <= 1'b0;
            wb_addr_r <= '0;
            wb_data_r <= 16'h0000;
            dcnt_r    <= 4'd0;
        end else if (wr_accept_s) begin
            wb_vld_r  <= 1'b1;
            wb_addr_r <= addr_idx_s;
            wb_data_r <= wrt_data;
            dcnt_r    <= CNT_LOAD;
        end else if (drain_done_s) begin
            wb_vld_r  <= 1'b0;
        end else if (wb_vld_r) begin
            dcnt_r    <= dcnt_r - 4'd1;
        end
    end

    // Array write port: commit the buffered word at the end of its drain.
    always_ff @(posedge clk) begin
        if (drain_done_s) begin
            mem_r[wb_addr_r] <= wb_data_r;
        end
    end

    // Read FSM: wait for any drain, run the array access, then hand back data.
    // WAIT_WB leaves only once the buffer is observed empty, which leaves one
    // turnaround cycle between the final drain write and the read access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            rd_data_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (re && we) begin
                        rd_data_r <= 16'h0000;
                    end else if (re) begin
                        if (fwd_hit_s) begin
                            rd_data_r <= wb_data_r;
                        end else if (wb_vld_r) begin
                            state_r <= WAIT_WB;
                        end else begin
                            state_r <= RD_BUSY;
                            cnt_r   <= CNT_LOAD;
                        end
                    end
                end
                WAIT_WB: begin
                    if (!wb_vld_r) begin
                        state_r <= RD_BUSY;
                        cnt_r   <= CNT_LOAD;
                    end
                end
                RD_BUSY: begin
                    if (cnt_r == 4'd0) begin
                        rd_data_r <= mem_r[addr_idx_s];
                        state_r   <= RD_DONE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RD_DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Stall: stores wait for the buffer, loads wait for the FSM to finish.
    always_comb begin
        stall = 1'b0;
        if (we) begin
            stall = !wr_accept_s;
        end else if (re) begin
            case (state_r)
                IDLE:    stall = !fwd_hit_s;
                WAIT_WB: stall = 1'b1;
                RD_BUSY: stall = 1'b1;
                RD_DONE: stall = 1'b0;
                default: stall = 1'b0;
            endcase
        end else begin
            stall = 1'b0;
        end
    end

    // Load data: zero when a store wins, forwarded word on a hit, else held.
    always_comb begin
        rd_data = rd_data_r;
        if (re && we) begin
            rd_data = 16'h0000;
        end else if (fwd_hit_s) begin
            rd_data = wb_data_r;
        end else begin
            rd_data = rd_data_r;
        end
    end

    // Quiesced when nothing is buffered and no load is in flight.
    always_comb begin
        quiesced = !wb_vld_r && (state_r == IDLE);
    end

endmodule
